// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX pipeline register payload.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned OP_W     = 6;

  localparam logic [XLEN-1:0] PC_RESET = 32'h8002_0000;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_LH    = 6'h21;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU   = 6'h25;

  localparam logic [OP_W-1:0]   FN_JR  = 6'h08;
  localparam logic [REG_AW-1:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm_ext;
    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   funct;
    logic [REG_AW-1:0] shamt;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] dest;
    logic              mem_read;
    logic              reg_write;
    logic              valid;
  } idex_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 fixed at 0.
// DECODE_WB_BYPASS_EN forwards same-cycle write data to the read ports.
module decode_stage_regfile
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  output logic [XLEN-1:0]   rs_data_o,
  output logic [XLEN-1:0]   rt_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef DECODE_WB_BYPASS_EN
    if (we_i && (wa_i != '0) && (wa_i == rs_addr_i)) rs_data_o = wd_i;
    if (we_i && (wa_i != '0) && (wa_i == rt_addr_i)) rt_data_o = wd_i;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: field/control decode, register read, immediate extend,
// load-use stall and the ID/EX register. Optional: DECODE_WB_BYPASS_EN (regfile bypass).
module decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        insn_valid,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  dest,
  output logic        mem_read,
  output logic        reg_write,
  output logic        valid_out
);

  idex_t idex_q, idex_d;

  logic [OP_W-1:0]   op_c;
  logic [OP_W-1:0]   fn_c;
  logic [REG_AW-1:0] rs_c, rt_c, rd_c;
  logic [XLEN-1:0]   rs_rd_c, rt_rd_c;
  logic              hazard_c;

  assign op_c = insn_in[31:26];
  assign rs_c = insn_in[25:21];
  assign rt_c = insn_in[20:16];
  assign rd_c = insn_in[15:11];
  assign fn_c = insn_in[5:0];

  decode_stage_regfile u_rf (
    .clock     (clock),
    .reset     (reset),
    .rs_addr_i (rs_c),
    .rt_addr_i (rt_c),
    .rs_data_o (rs_rd_c),
    .rt_data_o (rt_rd_c),
    .we_i      (wb_en),
    .wa_i      (wb_addr),
    .wd_i      (wb_data)
  );

  // Load in ID/EX whose destination feeds the instruction now being decoded.
  assign hazard_c = idex_q.valid && idex_q.mem_read && (idex_q.dest != '0) &&
                    ((idex_q.dest == rs_c) || (idex_q.dest == rt_c)) &&
                    insn_valid && !flush && !reset;
  assign stall = hazard_c;

  always_comb begin
    idex_d           = '0;
    idex_d.pc        = pc_in;
    idex_d.rs_data   = rs_rd_c;
    idex_d.rt_data   = rt_rd_c;
    idex_d.opcode    = op_c;
    idex_d.funct     = fn_c;
    idex_d.shamt     = insn_in[10:6];
    idex_d.rs_addr   = rs_c;
    idex_d.rt_addr   = rt_c;
    idex_d.mem_read  = is_load(op_c);
    idex_d.valid     = 1'b1;

    if ((op_c == OP_ANDI) || (op_c == OP_ORI) || (op_c == OP_XORI))
      idex_d.imm_ext = {16'h0000, insn_in[15:0]};
    else
      idex_d.imm_ext = {{16{insn_in[15]}}, insn_in[15:0]};

    if (op_c == OP_RTYPE)     idex_d.dest = rd_c;
    else if (op_c == OP_JAL)  idex_d.dest = REG_RA;
    else                      idex_d.dest = rt_c;

    if (op_c == OP_RTYPE)                         idex_d.reg_write = (fn_c != FN_JR);
    else if ((op_c >= 6'h08) && (op_c <= 6'h0F))  idex_d.reg_write = 1'b1;
    else                                          idex_d.reg_write = is_load(op_c) || (op_c == OP_JAL);

    if (idex_d.dest == '0) idex_d.reg_write = 1'b0;

    // Flush, stall and empty slots all become bubbles; the PC still advances.
    if (!insn_valid || flush || hazard_c) begin
      idex_d.valid     = 1'b0;
      idex_d.mem_read  = 1'b0;
      idex_d.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q    <= '0;
      idex_q.pc <= PC_RESET;
    end else begin
      idex_q    <= idex_d;
    end
  end

  assign pc_out    = idex_q.pc;
  assign rs_data   = idex_q.rs_data;
  assign rt_data   = idex_q.rt_data;
  assign imm_ext   = idex_q.imm_ext;
  assign opcode    = idex_q.opcode;
  assign funct     = idex_q.funct;
  assign shamt     = idex_q.shamt;
  assign rs_addr   = idex_q.rs_addr;
  assign rt_addr   = idex_q.rt_addr;
  assign dest      = idex_q.dest;
  assign mem_read  = idex_q.mem_read;
  assign reg_write = idex_q.reg_write;
  assign valid_out = idex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expected values hand-derived from the MIPS encodings.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] insn_in = 32'h0;
  logic        insn_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        stall;
  logic [31:0] pc_out, rs_data, rt_data, imm_ext;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rs_addr, rt_addr, dest;
  logic        mem_read, reg_write, valid_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] LW_R3   = 32'h8C23_0000; // lw   r3,0(r1)
  localparam logic [31:0] LW_R8   = 32'h8C28_0000; // lw   r8,0(r1)
  localparam logic [31:0] LW_R0   = 32'h8C20_0000; // lw   r0,0(r1)
  localparam logic [31:0] ADD_RS3 = 32'h0061_2020; // add  r4,r3,r1
  localparam logic [31:0] ADD_RT3 = 32'h0023_2020; // add  r4,r1,r3
  localparam logic [31:0] ADD_R0  = 32'h0001_2020; // add  r4,r0,r1

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

  decode_stage dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .insn_in(insn_in),
    .insn_valid(insn_valid), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .pc_out(pc_out), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .opcode(opcode), .funct(funct),
    .shamt(shamt), .rs_addr(rs_addr), .rt_addr(rt_addr), .dest(dest),
    .mem_read(mem_read), .reg_write(reg_write), .valid_out(valid_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic v, input logic f);
    insn_in = insn; pc_in = pc; insn_valid = v; flush = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_pc", pc_out, 32'h8002_0000);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memrd", 32'(mem_read), 32'd0);
    chk("rst_regwr", 32'(reg_write), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] ra, rb;
      ra = 5'(i); rb = 5'(31 - i);
      drive({6'h00, ra, rb, 5'd0, 5'd0, 6'h20}, 32'h8002_0000, 1'b1, 1'b0);
      step();
      chk("rst_rf_rs", rs_data, 32'h0);
      chk("rst_rf_rt", rt_data, 32'h0);
    end

    // ADDI r1,r0,5
    drive(32'h2001_0005, 32'h8002_0000, 1'b1, 1'b0);
    step();
    chk("addi_op", 32'(opcode), 32'h08);
    chk("addi_dest", 32'(dest), 32'd1);
    chk("addi_imm", imm_ext, 32'd5);
    chk("addi_rw", 32'(reg_write), 32'd1);
    chk("addi_valid", 32'(valid_out), 32'd1);
    chk("addi_pc", pc_out, 32'h8002_0000);
    chk("addi_mr", 32'(mem_read), 32'd0);
    chk("addi_rt", 32'(rt_addr), 32'd1);

    // Write back r1=5 during a bubble, then read it: or r6,r1,r0
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    drive(32'h0, 32'h8002_0004, 1'b0, 1'b0);
    step();
    wb_en = 1'b0;
    chk("bub_valid", 32'(valid_out), 32'd0);
    chk("bub_rw", 32'(reg_write), 32'd0);
    chk("bub_pc", pc_out, 32'h8002_0004);
    drive(32'h0020_3025, 32'h8002_0008, 1'b1, 1'b0);
    step();
    chk("or_rs", rs_data, 32'd5);
    chk("or_rt", rt_data, 32'd0);
    chk("or_dest", 32'(dest), 32'd6);
    chk("or_funct", 32'(funct), 32'h25);
    chk("or_rw", 32'(reg_write), 32'd1);

    // Immediate extension
    drive(32'h3402_8000, 32'h8002_000C, 1'b1, 1'b0); step();
    chk("ori_imm", imm_ext, 32'h0000_8000);
    drive(32'h2002_8000, 32'h8002_0010, 1'b1, 1'b0); step();
    chk("addi_neg_imm", imm_ext, 32'hFFFF_8000);
    drive(32'h3007_FFFF, 32'h8002_0014, 1'b1, 1'b0); step();
    chk("andi_imm", imm_ext, 32'h0000_FFFF);
    drive(32'h0000_0140, 32'h8002_0018, 1'b1, 1'b0); step(); // sll r0,r0,5
    chk("sll_shamt", 32'(shamt), 32'd5);
    chk("sll_rw_r0", 32'(reg_write), 32'd0);

    // JAL / JR / ADDI to r0
    drive(32'h0C00_0010, 32'h8002_001C, 1'b1, 1'b0); step();
    chk("jal_dest", 32'(dest), 32'd31);
    chk("jal_rw", 32'(reg_write), 32'd1);
    chk("jal_imm", imm_ext, 32'h10);
    drive(32'h03E0_0008, 32'h8002_0020, 1'b1, 1'b0); step();
    chk("jr_rw", 32'(reg_write), 32'd0);
    chk("jr_rs", 32'(rs_addr), 32'd31);
    drive(32'h2020_0001, 32'h8002_0024, 1'b1, 1'b0); step();
    chk("addi_r0_rw", 32'(reg_write), 32'd0);
    chk("addi_r0_valid", 32'(valid_out), 32'd1);

    // Load-use on rs: one stall cycle, bubble, then issue
    drive(LW_R3, 32'h8002_0028, 1'b1, 1'b0); step();
    chk("lw_mr", 32'(mem_read), 32'd1);
    chk("lw_rw", 32'(reg_write), 32'd1);
    chk("lw_dest", 32'(dest), 32'd3);
    drive(ADD_RS3, 32'h8002_002C, 1'b1, 1'b0);
    #1 chk("hz_rs_stall", 32'(stall), 32'd1);
    step();
    chk("hz_bub_valid", 32'(valid_out), 32'd0);
    chk("hz_bub_mr", 32'(mem_read), 32'd0);
    chk("hz_bub_rw", 32'(reg_write), 32'd0);
    chk("hz_bub_pc", pc_out, 32'h8002_002C);
    chk("hz_stall_gone", 32'(stall), 32'd0);
    step();
    chk("hz_add_valid", 32'(valid_out), 32'd1);
    chk("hz_add_dest", 32'(dest), 32'd4);
    chk("hz_add_rs", rs_data, 32'd0);
    chk("hz_add_rt", rt_data, 32'd5);

    // Load-use on rt
    drive(LW_R3, 32'h8002_0030, 1'b1, 1'b0); step();
    drive(ADD_RT3, 32'h8002_0034, 1'b1, 1'b0);
    #1 chk("hz_rt_stall", 32'(stall), 32'd1);
    step();
    chk("hz_rt_bub", 32'(valid_out), 32'd0);
    step();
    chk("hz_rt_issue", 32'(valid_out), 32'd1);

    // Back-to-back independent loads
    drive(LW_R3, 32'h8002_0038, 1'b1, 1'b0); step();
    drive(LW_R8, 32'h8002_003C, 1'b1, 1'b0);
    #1 chk("b2b_stall", 32'(stall), 32'd0);
    step();
    chk("b2b_valid", 32'(valid_out), 32'd1);
    chk("b2b_mr", 32'(mem_read), 32'd1);
    chk("b2b_dest", 32'(dest), 32'd8);

    // Flush beats hazard
    drive(LW_R3, 32'h8002_0040, 1'b1, 1'b0); step();
    drive(ADD_RS3, 32'h8002_0044, 1'b1, 1'b1);
    #1 chk("fl_stall", 32'(stall), 32'd0);
    step();
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_rw", 32'(reg_write), 32'd0);

    // insn_valid=0 suppresses hazard and makes a bubble
    drive(LW_R3, 32'h8002_0048, 1'b1, 1'b0); step();
    drive(ADD_RS3, 32'h8002_004C, 1'b0, 1'b0);
    #1 chk("iv_stall", 32'(stall), 32'd0);
    step();
    chk("iv_valid", 32'(valid_out), 32'd0);

    // Load into r0: no register write, no stall on r0 consumer
    drive(LW_R0, 32'h8002_0050, 1'b1, 1'b0); step();
    chk("lw0_mr", 32'(mem_read), 32'd1);
    chk("lw0_rw", 32'(reg_write), 32'd0);
    drive(ADD_R0, 32'h8002_0054, 1'b1, 1'b0);
    #1 chk("lw0_stall", 32'(stall), 32'd0);
    step();
    chk("lw0_add_valid", 32'(valid_out), 32'd1);

    // Write-back bypass on r5: add r9,r5,r0
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    drive(32'h00A0_4820, 32'h8002_0058, 1'b1, 1'b0); step();
    chk("byp_rs", rs_data, BYP_EXP);
    wb_en = 1'b0;
    step();
    chk("byp_after", rs_data, 32'hDEAD_BEEF);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    drive(32'h0000_4820, 32'h8002_005C, 1'b1, 1'b0); step();
    chk("r0_wb_rs", rs_data, 32'h0);
    chk("r0_wb_rt", rt_data, 32'h0);
    wb_en = 1'b0;
    step();
    chk("r0_after", rs_data, 32'h0);

    // Reset forces stall low and restores reset state
    drive(LW_R3, 32'h8002_0060, 1'b1, 1'b0); step();
    drive(ADD_RS3, 32'h8002_0064, 1'b1, 1'b0);
    reset = 1'b1;
    #1 chk("rst_hz_stall", 32'(stall), 32'd0);
    step();
    chk("rst2_pc", pc_out, 32'h8002_0000);
    chk("rst2_valid", 32'(valid_out), 32'd0);
    chk("rst2_mr", 32'(mem_read), 32'd0);
    reset = 1'b0;
    drive(32'h00A0_4820, 32'h8002_0068, 1'b1, 1'b0); step();
    chk("rst2_r5", rs_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the 5-stage MIPS core. Sits directly downstream of fetch.
- Consumes the fetched PC and the instruction word returned by instruction memory.
- Reads the 32x32 register file, decodes fields and control, and sign/zero-extends the immediate.
- Detects load-use hazards, drives the stall back to fetch, and registers the results into the ID/EX pipeline register for execute.

Parameters:
- PC_RESET, 32'h80020000, value of pc_out after reset (matches fetch base address)
- NUM_REGS, 32, register file depth (fixed at 32; address width 5)

Ports:
- clock  in  1  single pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- pc_in  in  32  PC of the instruction being decoded (from fetch pc_out)
- insn_in  in  32  instruction word from instruction memory
- insn_valid  in  1  insn_in is valid this cycle
- flush  in  1  branch/jump taken in execute (fetch do_branch); squash the current instruction
- wb_en  in  1  write-back register write enable
- wb_addr  in  5  write-back destination register
- wb_data  in  32  write-back data
- stall  out  1  combinational; holds fetch (feeds fetch stall)
- pc_out  out  32  registered PC to execute
- rs_data  out  32  registered rs operand
- rt_data  out  32  registered rt operand
- imm_ext  out  32  registered extended immediate
- opcode  out  6  registered insn[31:26]
- funct  out  6  registered insn[5:0]
- shamt  out  5  registered insn[10:6]
- rs_addr  out  5  registered insn[25:21]
- rt_addr  out  5  registered insn[20:16]
- dest  out  5  registered destination register
- mem_read  out  1  registered: instruction is a load
- reg_write  out  1  registered: instruction writes a register
- valid_out  out  1  registered: ID/EX holds a real instruction (0 = bubble)

Behaviour:
- Reset (synchronous):
  - pc_out=PC_RESET.
  - All other outputs 0, so the stage emits a bubble.
  - All 32 registers cleared.
  - stall=0 while reset is high.
- Latency: one cycle from insn_in/pc_in to the ID/EX outputs.
- Field decode:
  - dest=rd for opcode 0; dest=31 for JAL (0x03); dest=rt otherwise.
  - mem_read=1 for opcodes 0x20, 0x21, 0x23, 0x24, 0x25.
  - reg_write=1 for:
    - R-type, except JR (funct 0x08);
    - opcodes 0x08-0x0F;
    - the loads above;
    - JAL.
  - reg_write is forced to 0 when dest==0.
- Immediate: zero-extend insn[15:0] for ANDI/ORI/XORI (0x0C/0x0D/0x0E); sign-extend otherwise.
- Register file:
  - Write on posedge when wb_en and wb_addr!=0.
  - r0 always reads 0.
  - Reads are combinational.
- Hazard:
  - stall=1 when all of the following hold:
    - valid_out && mem_read (a load in ID/EX);
    - dest!=0;
    - dest==rs or dest==rt of insn_in;
    - insn_valid;
    - !flush.
  - While stall=1, the next ID/EX load is a bubble (valid_out=0, mem_read=0, reg_write=0).
  - The stall lasts exactly one cycle, because the load has left ID/EX by then.
- Flush:
  - flush=1 loads a bubble into ID/EX and forces stall=0.
  - flush takes priority over the hazard.
- insn_valid=0 loads a bubble.
- pc_out always updates with pc_in, including on bubbles.
- Back-to-back loads: a load following a load with no dependency proceeds without a stall.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when wb_en && wb_addr!=0 && wb_addr matches rs (or rt), the read returns wb_data in the same cycle (write-before-read).
- Undefined: the read returns the pre-write register contents. The write still completes at the posedge.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_JAL, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_ANDI, OP_ORI, OP_XORI);
  - FN_JR;
  - REG_RA=31;
  - PC_RESET.
- One sub-module, regfile: 32x32, two combinational read ports, one write port, r0 hardwired to 0, bypass under the macro.

Test Plan:
- Reset: assert reset 2 cycles -> pc_out=32'h80020000, valid_out=0, stall=0; every register reads 0.
- ADDI r1,r0,5 (insn 32'h20010005), pc_in=32'h80020000, then write back r1=5 -> next cycle opcode=0x08, dest=1, imm_ext=5, reg_write=1, valid_out=1; a subsequent read of r1 returns 5.
- ORI r2,r0,0x8000 -> imm_ext=32'h00008000. ADDI with imm 0x8000 -> imm_ext=32'hFFFF8000.
- Load-use hazard: LW r3,0(r1), then ADD r4,r3,r1 -> stall=1 for exactly one cycle, bubble in ID/EX, then ADD issues with valid_out=1.
- Flush: hazard conditions present plus flush=1 in the same cycle -> stall=0, next valid_out=0.
- Bypass: wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF, same cycle decoding rs=5 -> rs_data=32'hDEADBEEF with DECODE_WB_BYPASS_EN defined, old value without it. wb_addr=0 -> r0 stays 0.
